ct_rtu_ereg_flag_commit: RTL and testbench
==========================================

# ct_rtu_ereg_flag_commit

Retire-side reader of the extension-register (ereg) accumulate outputs. Collects the 6-bit accumulated flag values of up to three retiring vector/FP instructions per cycle and ORs them together. Delivers the result to CP0 through a valid/ack handshake so that fcsr.fflags and vxsat are updated exactly once per retired flag set. Sits in the RTU between the IDU PRF ereg accumulate buses and the CP0 fcsr update port.

## Interface
- No parameters. Flag layout is fixed: [0]=NX, [1]=UF, [2]=OF, [3]=DZ, [4]=NV, [5]=vxsat.
- forever_cpuclk  input  1  block clock, ungated.
- cpurst_b  input  1  asynchronous active-low reset.
- idu_rtu_retire0_ereg_vld  input  1  retire slot 0 carries a released ereg writeback.
- idu_rtu_retire0_ereg_data  input  6  slot 0 accumulated flags; already masked by the ereg release qualifier.
- idu_rtu_retire1_ereg_vld / idu_rtu_retire1_ereg_data  input  1 / 6  slot 1, same meaning as slot 0.
- idu_rtu_retire2_ereg_vld / idu_rtu_retire2_ereg_data  input  1 / 6  slot 2, same meaning as slot 0.
- cp0_rtu_ereg_upd_ack  input  1  CP0 accepts the presented update this cycle.
- rtu_cp0_ereg_upd_vld  output  1  update pending toward CP0.
- rtu_cp0_ereg_upd_data  output  6  flags to OR into fcsr/vxsat.
- rtu_cp0_ereg_empty  output  1  no flags held anywhere in the block.

## Operation
- Per-cycle merge: retire_data = OR over slots i of ({6{retire_i_ereg_vld}} & retire_i_ereg_data). retire_hit = (retire_data != 0). Valid slots carrying all-zero data are dropped and produce no update.
- Storage:
  - out_reg[5:0]: drives rtu_cp0_ereg_upd_data.
  - acc_reg[5:0] with acc_vld: collects retirements while out_reg is waiting for CP0.
- State machine, 2 states:
  - IDLE: rtu_cp0_ereg_upd_vld=0. On retire_hit: out_reg<=retire_data, go to SEND.
  - SEND: rtu_cp0_ereg_upd_vld=1 and out_reg is frozen.
    - No ack: on retire_hit, acc_reg<=acc_reg|retire_data and acc_vld<=1.
    - Ack with acc_vld or retire_hit: out_reg<=acc_reg|retire_data (acc_reg counts only when acc_vld), clear acc, stay in SEND.
    - Ack with neither: go to IDLE. out_reg keeps its value; it is don't-care while vld=0.
- Handshake: rtu_cp0_ereg_upd_data must not change while vld=1 and ack=0. A transfer completes on a cycle with vld=1 and ack=1. Ack while vld=0 is ignored.
- rtu_cp0_ereg_empty = (state==IDLE) & ~acc_vld. It is registered-state only and does not look at current-cycle retire inputs. CP0 uses it to hold fcsr/vxsat reads until it is 1.
- No flags are ever dropped. Flags are never committed twice. acc_reg saturates by OR, so it cannot overflow.
- Pipeline flush has no effect: every input is already retired.

## Timing
- Reset (async, cpurst_b=0):
  - state=IDLE, out_reg=0, acc_reg=0, acc_vld=0.
  - Outputs: upd_vld=0, upd_data=0, empty=1.
  - Reset asserted mid-SEND drops the pending update immediately, with no ack required.
- Latency: retire_hit in cycle N gives upd_vld=1 with data in cycle N+1.
- Ack in cycle M:
  - If acc_vld or retire_hit in M: the next update is presented in M+1 with no bubble.
  - Otherwise: upd_vld=0 in M+1.
- Simultaneous ack and retire_hit in SEND: the retire data goes into the next out_reg, never into the acknowledged one.
- Throughput: one update per cycle when CP0 acks every cycle.
- Maximum hold: unbounded. The block waits for ack indefinitely, and acc_reg keeps merging.

## Test plan
- Reset and idle:
  - cpurst_b low, then released with no retires -> upd_vld=0, upd_data=0, empty=1 for 10 cycles.
  - Slot0 vld with data 6'h00 -> still no update.
- Single update: slot1 vld data 6'h11, ack held 1 -> upd_vld=1, data=6'h11 exactly one cycle later; upd_vld=0 the cycle after; empty returns 1.
- Three-slot merge: slots 0/1/2 data 6'h01/6'h04/6'h20 in the same cycle -> single update data=6'h25.
- Backpressure:
  - ack=0; retire 6'h02 at N, 6'h08 at N+1, 6'h10 at N+2 -> upd_data stays 6'h02 and empty=0 throughout.
  - Ack at N+4 -> N+5 data=6'h18, and it holds until a second ack.
- Ack plus simultaneous retire: in SEND with acc holding 6'h01, ack together with retire 6'h20 -> next update data=6'h21; no cycle with upd_vld=0 between the two updates.
- Reset mid-operation: in SEND with acc_vld=1, pulse cpurst_b low for 1 cycle -> all outputs return to reset values asynchronously; no update is presented afterwards without a new retire.

Source files
------------

// File: rtl/ct_rtu_ereg_flag_commit_if.sv
// Retire-to-CP0 ereg flag bus: three retire slots in, one valid/ack update port out.
// master = IDU retire slots plus CP0 ack; slave = the flag commit block.
interface ct_rtu_ereg_flag_commit_if;
  logic       idu_rtu_retire0_ereg_vld;
  logic [5:0] idu_rtu_retire0_ereg_data;
  logic       idu_rtu_retire1_ereg_vld;
  logic [5:0] idu_rtu_retire1_ereg_data;
  logic       idu_rtu_retire2_ereg_vld;
  logic [5:0] idu_rtu_retire2_ereg_data;
  logic       cp0_rtu_ereg_upd_ack;
  logic       rtu_cp0_ereg_upd_vld;
  logic [5:0] rtu_cp0_ereg_upd_data;
  logic       rtu_cp0_ereg_empty;

  modport master (
    output idu_rtu_retire0_ereg_vld, idu_rtu_retire0_ereg_data,
    output idu_rtu_retire1_ereg_vld, idu_rtu_retire1_ereg_data,
    output idu_rtu_retire2_ereg_vld, idu_rtu_retire2_ereg_data,
    output cp0_rtu_ereg_upd_ack,
    input  rtu_cp0_ereg_upd_vld, rtu_cp0_ereg_upd_data, rtu_cp0_ereg_empty
  );

  modport slave (
    input  idu_rtu_retire0_ereg_vld, idu_rtu_retire0_ereg_data,
    input  idu_rtu_retire1_ereg_vld, idu_rtu_retire1_ereg_data,
    input  idu_rtu_retire2_ereg_vld, idu_rtu_retire2_ereg_data,
    input  cp0_rtu_ereg_upd_ack,
    output rtu_cp0_ereg_upd_vld, rtu_cp0_ereg_upd_data, rtu_cp0_ereg_empty
  );
endinterface

// File: rtl/ct_rtu_ereg_flag_commit.sv
// Merges retired ereg flags (NX,UF,OF,DZ,NV,vxsat) and hands them to CP0 once each
// through a valid/ack port; flags arriving while CP0 stalls are OR-accumulated.
module ct_rtu_ereg_flag_commit (
  input  logic                         forever_cpuclk,
  input  logic                         cpurst_b,
  ct_rtu_ereg_flag_commit_if.slave     ereg
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state_q;
  state_t     state_d;
  logic [5:0] out_reg;
  logic [5:0] out_d;
  logic [5:0] acc_reg;
  logic [5:0] acc_d;
  logic       acc_vld;
  logic       acc_vld_d;
  logic [5:0] retire_data;
  logic       retire_hit;

  // Slots with all-zero flags carry nothing to commit, so they never raise a hit.
  assign retire_data = ({6{ereg.idu_rtu_retire0_ereg_vld}} & ereg.idu_rtu_retire0_ereg_data)
                     | ({6{ereg.idu_rtu_retire1_ereg_vld}} & ereg.idu_rtu_retire1_ereg_data)
                     | ({6{ereg.idu_rtu_retire2_ereg_vld}} & ereg.idu_rtu_retire2_ereg_data);
  assign retire_hit  = |retire_data;

  always_comb begin
    state_d   = state_q;
    out_d     = out_reg;
    acc_d     = acc_reg;
    acc_vld_d = acc_vld;
    case (state_q)
      IDLE: begin
        if (retire_hit) begin
          out_d   = retire_data;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ereg.cp0_rtu_ereg_upd_ack) begin
          // Same-cycle retires go to the next update, never the acknowledged one.
          if (acc_vld || retire_hit) begin
            out_d = ({6{acc_vld}} & acc_reg) | retire_data;
          end else begin
            state_d = IDLE;
          end
          acc_d     = 6'h00;
          acc_vld_d = 1'b0;
        end else if (retire_hit) begin
          acc_d     = acc_reg | retire_data;
          acc_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= IDLE;
      out_reg <= 6'h00;
      acc_reg <= 6'h00;
      acc_vld <= 1'b0;
    end else begin
      state_q <= state_d;
      out_reg <= out_d;
      acc_reg <= acc_d;
      acc_vld <= acc_vld_d;
    end
  end

  assign ereg.rtu_cp0_ereg_upd_vld  = (state_q == SEND);
  assign ereg.rtu_cp0_ereg_upd_data = out_reg;
  assign ereg.rtu_cp0_ereg_empty    = (state_q == IDLE) && !acc_vld;

endmodule

// File: tb/tb_ct_rtu_ereg_flag_commit.sv
// Directed bench for the ereg flag commit block: inputs change and outputs are sampled on the falling edge.
module tb_ct_rtu_ereg_flag_commit;

  logic forever_cpuclk = 1'b0;
  logic cpurst_b       = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ct_rtu_ereg_flag_commit_if ereg_if ();

  ct_rtu_ereg_flag_commit dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .ereg           (ereg_if.slave)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [5:0] data, input logic empty);
    chk({tag, ".vld"},   {7'b0, ereg_if.rtu_cp0_ereg_upd_vld}, {7'b0, vld});
    chk({tag, ".data"},  {2'b0, ereg_if.rtu_cp0_ereg_upd_data}, {2'b0, data});
    chk({tag, ".empty"}, {7'b0, ereg_if.rtu_cp0_ereg_empty}, {7'b0, empty});
  endtask

  task automatic set_retire(input logic v0, input logic [5:0] d0,
                            input logic v1, input logic [5:0] d1,
                            input logic v2, input logic [5:0] d2);
    ereg_if.idu_rtu_retire0_ereg_vld  = v0;
    ereg_if.idu_rtu_retire0_ereg_data = d0;
    ereg_if.idu_rtu_retire1_ereg_vld  = v1;
    ereg_if.idu_rtu_retire1_ereg_data = d1;
    ereg_if.idu_rtu_retire2_ereg_vld  = v2;
    ereg_if.idu_rtu_retire2_ereg_data = d2;
  endtask

  task automatic tick();
    @(negedge forever_cpuclk);
  endtask

  initial begin
    set_retire(0, 6'h00, 0, 6'h00, 0, 6'h00);
    ereg_if.cp0_rtu_ereg_upd_ack = 1'b0;
    #12;
    chk_out("rst_hold", 1'b0, 6'h00, 1'b1);
    tick();
    cpurst_b = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out("idle", 1'b0, 6'h00, 1'b1);
    end

    // valid slot with zero flags is dropped
    set_retire(1, 6'h00, 0, 6'h00, 0, 6'h00);
    tick();
    set_retire(0, 6'h00, 0, 6'h00, 0, 6'h00);
    chk_out("zero_slot", 1'b0, 6'h00, 1'b1);
    tick();
    chk_out("zero_slot2", 1'b0, 6'h00, 1'b1);

    // single update with ack held high
    ereg_if.cp0_rtu_ereg_upd_ack = 1'b1;
    set_retire(0, 6'h00, 1, 6'h11, 0, 6'h00);
    tick();
    set_retire(0, 6'h00, 0, 6'h00, 0, 6'h00);
    chk_out("single", 1'b1, 6'h11, 1'b0);
    tick();
    chk_out("single_done", 1'b0, 6'h11, 1'b1);

    // three-slot merge
    set_retire(1, 6'h01, 1, 6'h04, 1, 6'h20);
    tick();
    set_retire(0, 6'h00, 0, 6'h00, 0, 6'h00);
    chk_out("merge", 1'b1, 6'h25, 1'b0);
    tick();
    chk_out("merge_done", 1'b0, 6'h25, 1'b1);

    // backpressure: out_reg frozen while acc collects
    ereg_if.cp0_rtu_ereg_upd_ack = 1'b0;
    set_retire(1, 6'h02, 0, 6'h00, 0, 6'h00);
    tick();
    chk_out("bp_n", 1'b1, 6'h02, 1'b0);
    set_retire(0, 6'h00, 1, 6'h08, 0, 6'h00);
    tick();
    chk_out("bp_n1", 1'b1, 6'h02, 1'b0);
    set_retire(0, 6'h00, 0, 6'h00, 1, 6'h10);
    tick();
    chk_out("bp_n2", 1'b1, 6'h02, 1'b0);
    set_retire(0, 6'h00, 0, 6'h00, 0, 6'h00);
    tick();
    chk_out("bp_n3", 1'b1, 6'h02, 1'b0);
    ereg_if.cp0_rtu_ereg_upd_ack = 1'b1;
    tick();
    ereg_if.cp0_rtu_ereg_upd_ack = 1'b0;
    chk_out("bp_acc", 1'b1, 6'h18, 1'b0);
    tick();
    chk_out("bp_hold1", 1'b1, 6'h18, 1'b0);
    tick();
    chk_out("bp_hold2", 1'b1, 6'h18, 1'b0);
    ereg_if.cp0_rtu_ereg_upd_ack = 1'b1;
    tick();
    chk_out("bp_done", 1'b0, 6'h18, 1'b1);
    tick();
    chk_out("ack_idle", 1'b0, 6'h18, 1'b1);

    // ack together with retire: no bubble, retire lands in the next update
    ereg_if.cp0_rtu_ereg_upd_ack = 1'b0;
    set_retire(1, 6'h04, 0, 6'h00, 0, 6'h00);
    tick();
    chk_out("ar_first", 1'b1, 6'h04, 1'b0);
    set_retire(0, 6'h00, 1, 6'h01, 0, 6'h00);
    tick();
    chk_out("ar_acc", 1'b1, 6'h04, 1'b0);
    set_retire(0, 6'h00, 0, 6'h00, 1, 6'h20);
    ereg_if.cp0_rtu_ereg_upd_ack = 1'b1;
    tick();
    set_retire(0, 6'h00, 0, 6'h00, 0, 6'h00);
    chk_out("ar_next", 1'b1, 6'h21, 1'b0);
    tick();
    chk_out("ar_done", 1'b0, 6'h21, 1'b1);

    // asynchronous reset while SEND with acc_vld set
    ereg_if.cp0_rtu_ereg_upd_ack = 1'b0;
    set_retire(1, 6'h02, 0, 6'h00, 0, 6'h00);
    tick();
    set_retire(1, 6'h04, 0, 6'h00, 0, 6'h00);
    tick();
    set_retire(0, 6'h00, 0, 6'h00, 0, 6'h00);
    chk_out("pre_rst", 1'b1, 6'h02, 1'b0);
    #2;
    cpurst_b = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 6'h00, 1'b1);
    tick();
    cpurst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("post_rst", 1'b0, 6'h00, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
